// File: rtl/sccb_config_sequencer.sv
// SCCB configuration sequencer: after a start pulse and a power-up wait it
// walks a synchronous ROM of {reg, val} words and issues one 3-phase SCCB
// write per entry through the byte transmitter's strobe/busy handshake.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   i_start           start pulse, honoured in IDLE/DONE/ERROR
//   o_rom_addr        ROM entry index
//   i_rom_data        ROM word, valid one cycle after o_rom_addr changes
//   o_sccb_data       byte to the transmitter
//   o_sccb_ready      one-cycle strobe qualifying o_sccb_data
//   o_sccb_last       set with the value byte strobe (stop follows it)
//   i_sccb_busy       transmitter busy
//   o_busy            sequence in progress
//   o_done            table finished (level)
//   o_error           handshake timeout (level)
//   o_count           register writes since the last start (saturating)
module sccb_config_sequencer #(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter logic [7:0]  DeviceAddress  = 8'h42,
    parameter int unsigned PowerUpDelayMs = 10,
    parameter int unsigned AckTimeout     = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic [7:0]  o_sccb_data,
    output logic        o_sccb_ready,
    output logic        o_sccb_last,
    input  logic        i_sccb_busy,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [7:0]  o_count
);

    localparam int unsigned MsRaw = ClockFrequency / 1000;
    localparam int unsigned MsDiv = (MsRaw == 0) ? 1 : MsRaw;

    localparam logic [31:0] MsCycles    = 32'(MsDiv);
    localparam logic [31:0] PwrupCycles = 32'(PowerUpDelayMs * MsDiv);
    localparam logic [31:0] AckCycles   = 32'(AckTimeout);

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        DECODE,
        SEND,
        WAIT_ACK,
        WAIT_IDLE,
        DELAY,
        DONE,
        ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_q,  addr_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  data_q,  data_d;
    logic        ready_q, ready_d;
    logic        last_q,  last_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] cnt_q,   cnt_d;
    logic [7:0]  reg_q,   reg_d;
    logic [7:0]  val_q,   val_d;

    logic rom_end;
    logic rom_delay;
    logic tick_done;
    logic ack_first;
    logic addr_wrap;

    assign rom_end   = (i_rom_data == 16'hFFFF);
    assign rom_delay = (i_rom_data[15:8] == 8'hF0);

    // cnt_q is a shared down-counter: power-up, inline delay and ack
    // timeout never overlap. A zero load still spends one cycle in state.
    assign tick_done = (cnt_q <= 32'd1);

    // The strobe is registered, so the first WAIT_ACK cycle is the strobe
    // cycle itself; busy seen there predates the strobe and is ignored.
    assign ack_first = (cnt_q == AckCycles);

    // Leaving entry 255 without an end marker finishes the table.
    assign addr_wrap = (addr_q == 8'hFF);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) state_d = PWRUP;
            end
            PWRUP: begin
                if (tick_done) state_d = FETCH;
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                if (rom_end)        state_d = DONE;
                else if (rom_delay) state_d = DELAY;
                else                state_d = SEND;
            end
            SEND: begin
                if (!i_sccb_busy) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!ack_first && i_sccb_busy) begin
                    state_d = WAIT_IDLE;
                end else if (cnt_q == 32'd0) begin
                    state_d = ERROR;
                end
            end
            WAIT_IDLE: begin
                if (!i_sccb_busy) begin
                    if (phase_q != 2'd3) state_d = SEND;
                    else if (addr_wrap)  state_d = DONE;
                    else                 state_d = FETCH;
                end
            end
            DELAY: begin
                if (tick_done) begin
                    state_d = addr_wrap ? DONE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state logic
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        ready_d = 1'b0;
        last_d  = 1'b0;
        phase_d = phase_q;
        reg_d   = reg_q;
        val_d   = val_q;
        cnt_d   = (cnt_q != 32'd0) ? cnt_q - 32'd1 : 32'd0;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    addr_d  = 8'd0;
                    count_d = 8'd0;
                    cnt_d   = PwrupCycles;
                end
            end
            DECODE: begin
                reg_d   = i_rom_data[15:8];
                val_d   = i_rom_data[7:0];
                phase_d = 2'd1;
                cnt_d   = 32'(i_rom_data[7:0]) * MsCycles;
            end
            SEND: begin
                if (!i_sccb_busy) begin
                    ready_d = 1'b1;
                    last_d  = (phase_q == 2'd3);
                    cnt_d   = AckCycles;
                    unique case (phase_q)
                        2'd1:    data_d = DeviceAddress;
                        2'd2:    data_d = reg_q;
                        default: data_d = val_q;
                    endcase
                end
            end
            WAIT_IDLE: begin
                if (!i_sccb_busy) begin
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        addr_d = addr_q + 8'd1;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                end
            end
            DELAY: begin
                if (tick_done) addr_d = addr_q + 8'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= 8'd0;
            count_q <= 8'd0;
            data_q  <= 8'd0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            phase_q <= 2'd0;
            cnt_q   <= 32'd0;
            reg_q   <= 8'd0;
            val_q   <= 8'd0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
        end
    end

    // Status outputs decoded from state
    always_comb begin
        o_busy  = 1'b1;
        o_done  = 1'b0;
        o_error = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_busy = 1'b0;
            end
            DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            ERROR: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_rom_addr   = addr_q;
    assign o_count      = count_q;
    assign o_sccb_data  = data_q;
    assign o_sccb_ready = ready_q;
    assign o_sccb_last  = last_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: ROM and transmitter models, a table-walk
// reference model for the expected strobe stream, and end-state checks.
module tb_sccb_config_sequencer;

    localparam int P = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_start = 1'b0;
    logic        i_sccb_busy = 1'b0;
    logic [15:0] i_rom_data = 16'h0;
    logic [7:0]  o_rom_addr;
    logic [7:0]  o_sccb_data;
    logic [7:0]  o_count;
    logic        o_sccb_ready;
    logic        o_sccb_last;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    sccb_config_sequencer #(
        .ClockFrequency(1000),
        .DeviceAddress (8'h42),
        .PowerUpDelayMs(P),
        .AckTimeout    (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_start     (i_start),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_sccb_data (o_sccb_data),
        .o_sccb_ready(o_sccb_ready),
        .o_sccb_last (o_sccb_last),
        .i_sccb_busy (i_sccb_busy),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_count     (o_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] addr;
        logic [7:0] cnt;
    } strobe_t;

    logic [15:0] rom [256];
    strobe_t     exp_q[$];
    int          strobe_cyc[$];
    logic [7:0]  obs_data[$];
    strobe_t     e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int t_end = 0;
    bit xmit_en = 1'b1;
    int busy_min = 1;
    int busy_max = 1;
    int busy_left = 0;

    always @(posedge CLK) i_rom_data <= rom[o_rom_addr];
    always @(posedge CLK) cyc++;

    // Transmitter: busy rises the cycle after a strobe, stays for N cycles.
    always @(negedge CLK) begin
        if (busy_left > 0) begin
            i_sccb_busy = 1'b1;
            busy_left--;
        end else begin
            i_sccb_busy = 1'b0;
        end
        if (o_sccb_ready && xmit_en) begin
            busy_left = $urandom_range(busy_max, busy_min);
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every strobe is compared with the head of the expected stream.
    always @(negedge CLK) begin
        if (o_sccb_ready) begin
            strobe_cyc.push_back(cyc);
            obs_data.push_back(o_sccb_data);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_strobe: got data %0h, none expected",
                         o_sccb_data);
            end else begin
                e = exp_q.pop_front();
                if (o_sccb_data !== e.data || o_sccb_last !== e.last ||
                    o_rom_addr !== e.addr || o_count !== e.cnt) begin
                    errors++;
                    $display("FAIL strobe: got d=%0h l=%0b a=%0h c=%0h expected d=%0h l=%0b a=%0h c=%0h",
                             o_sccb_data, o_sccb_last, o_rom_addr, o_count,
                             e.data, e.last, e.addr, e.cnt);
                end
            end
        end
        if (!RST) begin
            checks++;
            if (int'(o_busy) + int'(o_done) + int'(o_error) > 1) begin
                errors++;
                $display("FAIL status_onehot: got b=%0b d=%0b e=%0b expected at most one",
                         o_busy, o_done, o_error);
            end
        end
    end

    // Walk the table as the sequencer should; returns writes expected.
    function automatic int build_model(input bit ack,
                                       output logic [7:0] end_addr);
        int n = 0;
        logic [7:0] c;
        logic [15:0] w;
        exp_q.delete();
        end_addr = 8'd0;
        for (int a = 0; a < 256; a++) begin
            w = rom[a];
            if (w == 16'hFFFF) begin
                end_addr = 8'(a);
                return n;
            end
            if (w[15:8] != 8'hF0) begin
                c = 8'(n);
                exp_q.push_back('{8'h42, 1'b0, 8'(a), c});
                if (!ack) return 0;
                exp_q.push_back('{w[15:8], 1'b0, 8'(a), c});
                exp_q.push_back('{w[7:0], 1'b1, 8'(a), c});
                if (n < 255) n++;
            end
        end
        return n;
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        strobe_cyc.delete();
        obs_data.delete();
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        t_start = cyc;
        check("busy_after_start", o_busy, 1);
        check("start_clr_done", o_done | o_error, 0);
        check("start_clr_count", o_count, 0);
        check("start_clr_addr", o_rom_addr, 0);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(o_done || o_error) && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!(o_done || o_error)) begin
            errors++;
            $display("FAIL end_timeout: got no done/error expected one");
        end
        t_end = cyc;
    endtask

    task automatic wait_strobes(input int k);
        int n = 0;
        while (strobe_cyc.size() < k && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("strobe_wait", strobe_cyc.size() >= k, 1);
    endtask

    task automatic finish_run(input bit ok, input int cnt,
                              input logic [7:0] addr);
        wait_end();
        check("end_done", o_done, ok);
        check("end_error", o_error, !ok);
        check("end_busy", o_busy, 0);
        check("end_count", o_count, cnt);
        check("end_addr", o_rom_addr, addr);
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, o_rom_addr, 0);
        check({tag, "_data"}, o_sccb_data, 0);
        check({tag, "_ready"}, o_sccb_ready, 0);
        check({tag, "_last"}, o_sccb_last, 0);
        check({tag, "_stat"}, {o_busy, o_done, o_error}, 0);
        check({tag, "_count"}, o_count, 0);
    endtask

    logic [7:0] ea;
    int         ec;
    bit         addr_held;
    logic [7:0] lit [6];

    initial begin
        rom_clear();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_reset_vals("reset");

        // Two writes, 20-cycle transmitter
        rom_clear();
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        busy_min = 20;
        busy_max = 20;
        ec = build_model(1'b1, ea);
        start_pulse();
        finish_run(1'b1, ec, ea);
        check("two_count_lit", o_count, 2);
        lit = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h01};
        check("two_nstrobe", obs_data.size(), 6);
        for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
            check($sformatf("two_byte%0d", i), obs_data[i], lit[i]);
        end

        // Delay entry before a write
        rom_clear();
        rom[0] = 16'hF005;
        rom[1] = 16'h3A04;
        busy_min = 1;
        busy_max = 5;
        ec = build_model(1'b1, ea);
        start_pulse();
        finish_run(1'b1, ec, ea);
        check("delay_count_lit", o_count, 1);
        check("delay_gap",
              strobe_cyc.size() > 0 && strobe_cyc[0] - t_start >= P + 6, 1);

        // Ack timeout: transmitter never answers
        rom_clear();
        rom[0] = 16'h1280;
        xmit_en = 1'b0;
        ec = build_model(1'b0, ea);
        start_pulse();
        finish_run(1'b0, 0, 8'd0);
        check("to_nstrobe", strobe_cyc.size(), 1);
        check("to_latency",
              strobe_cyc.size() > 0 ? t_end - strobe_cyc[0] : -1, 9);
        xmit_en = 1'b1;

        // Empty table, restarted from ERROR
        rom_clear();
        ec = build_model(1'b1, ea);
        start_pulse();
        finish_run(1'b1, 0, 8'd0);
        check("empty_time", t_end - t_start, P + 2);
        check("empty_nstrobe", strobe_cyc.size(), 0);

        // Zero-ms delay and a 0xFF register byte
        rom_clear();
        rom[0] = 16'hF000;
        rom[1] = 16'hFF12;
        rom[2] = 16'h0000;
        ec = build_model(1'b1, ea);
        start_pulse();
        finish_run(1'b1, ec, ea);
        check("codes_count_lit", o_count, 2);

        // Reset during WAIT_IDLE of phase 2, then restart
        rom_clear();
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        busy_min = 6;
        busy_max = 6;
        ec = build_model(1'b1, ea);
        start_pulse();
        wait_strobes(2);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_vals("midrst");
        RST = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 100 && (i_sccb_busy || busy_left > 0); n++)
            @(negedge CLK);
        strobe_cyc.delete();
        obs_data.delete();
        ec = build_model(1'b1, ea);
        start_pulse();
        finish_run(1'b1, ec, ea);
        check("midrst_first", obs_data.size() > 0 ? obs_data[0] : 0,
              8'h42);

        // Start held high while entry 1 is in flight
        rom_clear();
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        busy_min = 12;
        busy_max = 12;
        ec = build_model(1'b1, ea);
        start_pulse();
        wait_strobes(4);
        addr_held = 1'b1;
        i_start = 1'b1;
        repeat (25) begin
            @(negedge CLK);
            if (o_rom_addr != 8'd1) addr_held = 1'b0;
        end
        i_start = 1'b0;
        check("ign_addr_held", addr_held, 1);
        finish_run(1'b1, ec, ea);
        check("ign_nstrobe", obs_data.size(), 6);

        // Random tables
        for (int it = 0; it < 4; it++) begin
            int len;
            rom_clear();
            len = $urandom_range(12, 1);
            for (int a = 0; a < len; a++) begin
                if ($urandom_range(3, 0) == 0) begin
                    rom[a] = {8'hF0, 8'($urandom_range(4, 0))};
                end else begin
                    rom[a] = {8'($urandom_range(8'hEF, 0)),
                              8'($urandom_range(255, 0))};
                end
            end
            busy_min = 1;
            busy_max = $urandom_range(6, 1);
            ec = build_model(1'b1, ea);
            start_pulse();
            finish_run(1'b1, ec, ea);
        end

        // Full table without end marker: wrap and saturate
        rom_clear();
        for (int a = 0; a < 256; a++) begin
            rom[a] = {8'($urandom_range(8'hEF, 0)),
                      8'($urandom_range(255, 0))};
        end
        busy_min = 1;
        busy_max = 1;
        ec = build_model(1'b1, ea);
        start_pulse();
        finish_run(1'b1, ec, ea);
        check("wrap_count_lit", o_count, 255);
        check("wrap_addr_lit", o_rom_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_config_sequencer.md
# sccb_config_sequencer

Table-driven register-write sequencer that sits directly upstream of the SCCB byte transmitter and configures the camera after power-up. On a start pulse it waits a power-up delay, then walks an external synchronous ROM of `{register, value}` entries. For each entry it issues one 3-phase SCCB write (device ID, register, value) through the transmitter's strobe/busy handshake, and it executes inline millisecond delays. It reports completion, registers written, and a handshake timeout error.

## Interface
- `ClockFrequency`, 50_000_000: system clock in Hz; one ms tick = `ClockFrequency/1000` cycles.
- `DeviceAddress`, 8'h42: SCCB write ID, sent as phase 1 of every write.
- `PowerUpDelayMs`, 10: ms waited after start before the first ROM fetch.
- `AckTimeout`, 1024: max cycles to wait for `i_sccb_busy` to rise after a strobe.
- `CLK`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  reset; one clock; reset is synchronous and active-high.
- `i_start`  in  1  start pulse; honoured only in IDLE, DONE or ERROR.
- `o_rom_addr`  out  8  ROM entry index.
- `i_rom_data`  in  16  ROM word `{reg[15:8], val[7:0]}`, valid one cycle after `o_rom_addr` changes.
- `o_sccb_data`  out  8  byte to transmitter.
- `o_sccb_ready`  out  1  one-cycle strobe: `o_sccb_data` valid.
- `o_sccb_last`  out  1  high with strobe on phase 3 (value byte): transmitter issues stop after it.
- `i_sccb_busy`  in  1  transmitter busy.
- `o_busy`  out  1  sequence in progress.
- `o_done`  out  1  level; table finished successfully.
- `o_error`  out  1  level; ack timeout occurred.
- `o_count`  out  8  entries written since last start, excluding delay entries.

## Operation
- ROM word decode:
  - 16'hFFFF = end of table.
  - 16'hF0xx = delay xx ms; xx=0 means no wait.
  - Anything else = register write.
- States: IDLE, PWRUP, FETCH, DECODE, SEND, WAIT_ACK, WAIT_IDLE, DELAY, DONE, ERROR.
- IDLE --`i_start`--> PWRUP. Start clears `o_count`, `o_done`, `o_error` and sets `o_rom_addr`=0.
- PWRUP: counts `PowerUpDelayMs` ms, then goes to FETCH.
- FETCH: one cycle for ROM latency, then DECODE.
- DECODE:
  - end → DONE.
  - delay → DELAY (loads xx).
  - write → SEND with phase=1.
- SEND:
  - Waits while `i_sccb_busy`=1.
  - When busy=0, asserts `o_sccb_ready` for exactly one cycle with phase data: 1=`DeviceAddress`, 2=reg, 3=val. `o_sccb_last`=1 on phase 3 only.
  - Then WAIT_ACK.
- WAIT_ACK: busy=1 → WAIT_IDLE. If `AckTimeout` cycles elapse with busy low → ERROR.
- WAIT_IDLE: on busy=0:
  - phase<3: phase+1 → SEND.
  - phase=3: `o_count`+1, `o_rom_addr`+1 → FETCH.
- DELAY: counts xx ms, then `o_rom_addr`+1 → FETCH.
- DONE / ERROR: hold outputs. `i_start` restarts from addr 0 (→PWRUP).
- Address wrap: after entry 255, if no end marker is found, `o_rom_addr` wraps to 0 and the sequencer → DONE. `o_count` saturates at 255.
- `o_busy`=1 in every state except IDLE, DONE and ERROR.

## Timing
- Reset values: state IDLE, `o_rom_addr`=0, `o_sccb_data`=0, `o_sccb_ready`=0, `o_sccb_last`=0, `o_busy`=0, `o_done`=0, `o_error`=0, `o_count`=0.
- Reset mid-operation aborts immediately. A strobe in flight is dropped: `o_sccb_ready` is low the cycle after `RST`.
- Start accepted at edge T; `o_busy`=1 from T+1.
- PWRUP lasts `PowerUpDelayMs*ClockFrequency/1000` cycles exactly.
- Strobe at cycle S: busy rising at S+1 is the earliest accepted ack. Timeout fires if busy is still 0 at S+`AckTimeout`; ERROR is entered at the next edge.
- Busy may rise and fall across any number of cycles. Back-to-back strobes are never closer than 3 cycles.
- ROM address changes only in the cycle leaving WAIT_IDLE or DELAY. `i_rom_data` is sampled in DECODE only.
- `i_start` while `o_busy`=1 is ignored.

## Test plan
- **Two writes:** ROM {0x1280, 0x1101, FFFF}, transmitter model busy 20 cycles per byte.
  - Strobes: 0x42, 0x12, 0x80(last), 0x42, 0x11, 0x01(last).
  - End state: `o_count`=2, `o_done`=1, `o_busy`=0.
- **Delay entry:** ROM {F005, 0x3A04, FFFF}, `ClockFrequency`=1000 (1 cycle/ms).
  - First strobe occurs ≥5 cycles after first DECODE.
  - End state: `o_count`=1.
- **Ack timeout:** busy tied low, `AckTimeout`=8.
  - Exactly one strobe (0x42).
  - `o_error`=1 at S+9, `o_busy`=0, `o_done`=0.
- **Empty table:** ROM {FFFF}.
  - No strobes.
  - `o_done`=1, `o_count`=0 after PWRUP+2 cycles.
- **Reset mid-write:** assert `RST` during WAIT_IDLE of phase 2.
  - Next cycle: all outputs at reset values.
  - A new `i_start` resends from entry 0, phase 1.
- **Start ignored while busy:** pulse `i_start` during SEND.
  - Sequence unchanged.
  - `o_rom_addr` is not reset.
